// File: rtl/fetch_defs.sv
// rtl/fetch_defs.sv - shared fetch-stage encodings and constants
package fetch_defs;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - synchronous power-of-two FIFO with flush and combinational head
module fifo_sync #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Flush wins over any push/pop in the same cycle
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - instruction prefetch: sequential fetch FSM feeding a FIFO to IF/ID
module fetch_prefetch_queue
  import fetch_defs::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              hold,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_addr_q, req_addr_d;

  logic                  push, pop, full, empty;
  logic [CNT_W-1:0]      count;
  logic [CNT_W:0]        post_cnt;
  logic [2*INST_W-1:0]   head_data;

  fifo_sync #(
    .WIDTH (2 * INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({mem_rdata, req_addr_q + 32'd4}),
    .pop       (pop),
    .flush     (redirect),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head_data (head_data)
  );

  assign inst_valid = ~empty;
  assign inst       = inst_valid ? head_data[2*INST_W-1:INST_W] : NOP_INST;
  assign inst_pc4   = inst_valid ? head_data[31:0] : 32'h0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    pop        = inst_valid & ~hold & ~redirect;
    mem_req    = (state_q != FS_IDLE);
    mem_addr   = mem_req ? req_addr_q : fetch_pc_q;
    post_cnt   = {1'b0, count} + (CNT_W + 1)'(1) - (CNT_W + 1)'(pop);

    unique case (state_q)
      FS_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (!(full && !pop)) begin
          state_d    = FS_WAIT;
          req_addr_d = fetch_pc_q;
        end
      end
      FS_WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = mem_ack ? FS_IDLE : FS_DROP;
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = req_addr_q + 32'd4;
          // Chain the next request only if the FIFO still has room after this push
          if (post_cnt < DEPTH_C) begin
            req_addr_d = req_addr_q + 32'd4;
          end else begin
            state_d = FS_IDLE;
          end
        end
      end
      FS_DROP: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end
        if (mem_ack) begin
          state_d = FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - directed self-checking bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        hold;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc4;

  int checks = 0;
  int errors = 0;
  int nreq;

  fetch_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hold        (hold),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc4    (inst_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign mem_rdata = word_at(mem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    mem_ack     = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    hold        = 1'b0;

    // Reset values and zero-wait streaming
    step();
    step();
    chk("rst_req",   {31'b0, mem_req},    32'd0);
    chk("rst_addr",  mem_addr,            32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst",  inst,                32'h0);
    chk("rst_pc4",   inst_pc4,            32'h0);
    reset = 1'b1;
    step();
    chk("s_c1_req",   {31'b0, mem_req},    32'd1);
    chk("s_c1_addr",  mem_addr,            32'h0);
    chk("s_c1_valid", {31'b0, inst_valid}, 32'd0);
    step();
    chk("s_c2_valid", {31'b0, inst_valid}, 32'd1);
    chk("s_c2_inst",  inst,                word_at(32'h0));
    chk("s_c2_pc4",   inst_pc4,            32'h4);
    chk("s_c2_addr",  mem_addr,            32'h4);
    step();
    chk("s_c3_pc4",   inst_pc4,            32'h8);
    chk("s_c3_inst",  inst,                word_at(32'h4));
    chk("s_c3_addr",  mem_addr,            32'h8);
    step();
    chk("s_c4_pc4",   inst_pc4,            32'hC);

    // Hold fills the FIFO: exactly DEPTH requests, then idle
    hold = 1'b1;
    do_reset();
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_req && mem_ack) nreq++;
    end
    chk("hold_nreq",  nreq,                32'd4);
    chk("hold_req",   {31'b0, mem_req},    32'd0);
    chk("hold_valid", {31'b0, inst_valid}, 32'd1);
    chk("hold_pc4",   inst_pc4,            32'h4);
    hold = 1'b0;
    step();
    chk("rel_req",  {31'b0, mem_req}, 32'd1);
    chk("rel_addr", mem_addr,         32'h10);
    chk("rel_pc4",  inst_pc4,         32'h8);
    step();
    chk("rel2_pc4",  inst_pc4, 32'hC);
    chk("rel2_addr", mem_addr, 32'h14);

    // Three-cycle ack latency: address held, one entry per four cycles
    mem_ack = 1'b0;
    do_reset();
    step();
    chk("lat_c1_req",  {31'b0, mem_req}, 32'd1);
    chk("lat_c1_addr", mem_addr,         32'h0);
    step();
    chk("lat_c2_addr", mem_addr, 32'h0);
    step();
    chk("lat_c3_addr", mem_addr, 32'h0);
    step();
    mem_ack = 1'b1;
    chk("lat_c4_addr",  mem_addr,            32'h0);
    chk("lat_c4_valid", {31'b0, inst_valid}, 32'd0);
    step();
    mem_ack = 1'b0;
    chk("lat_c5_valid", {31'b0, inst_valid}, 32'd1);
    chk("lat_c5_pc4",   inst_pc4,            32'h4);
    chk("lat_c5_inst",  inst,                word_at(32'h0));
    chk("lat_c5_addr",  mem_addr,            32'h4);
    step();
    chk("lat_c6_valid", {31'b0, inst_valid}, 32'd0);
    chk("lat_c6_addr",  mem_addr,            32'h4);
    step();
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("lat_c9_pc4",  inst_pc4, 32'h8);
    chk("lat_c9_inst", inst,     word_at(32'h4));

    // Redirect while a request is pending: old data dropped
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("rd_valid",    {31'b0, inst_valid}, 32'd0);
    chk("rd_drop_req", {31'b0, mem_req},    32'd1);
    chk("rd_drop_adr", mem_addr,            32'h8);
    step();
    mem_ack = 1'b1;
    step();
    chk("rd_idle_req",   {31'b0, mem_req},    32'd0);
    chk("rd_idle_valid", {31'b0, inst_valid}, 32'd0);
    step();
    chk("rd_new_req",  {31'b0, mem_req}, 32'd1);
    chk("rd_new_addr", mem_addr,         32'h40);
    step();
    chk("rd_new_valid", {31'b0, inst_valid}, 32'd1);
    chk("rd_new_pc4",   inst_pc4,            32'h44);
    chk("rd_new_inst",  inst,                word_at(32'h40));

    // Redirect coinciding with ack and pop at count=2
    hold = 1'b1;
    step();
    hold        = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    chk("rda_pre_pc4",  inst_pc4, 32'h44);
    chk("rda_pre_addr", mem_addr, 32'h48);
    step();
    redirect = 1'b0;
    chk("rda_valid", {31'b0, inst_valid}, 32'd0);
    chk("rda_req",   {31'b0, mem_req},    32'd0);
    chk("rda_addr",  mem_addr,            32'h100);
    step();
    chk("rda_new_req",  {31'b0, mem_req}, 32'd1);
    chk("rda_new_addr", mem_addr,         32'h100);
    step();
    chk("rda_new_pc4",  inst_pc4, 32'h104);
    chk("rda_new_inst", inst,     word_at(32'h100));

    // Reset asserted mid-request
    mem_ack = 1'b0;
    reset   = 1'b0;
    step();
    chk("mrst_req",   {31'b0, mem_req},    32'd0);
    chk("mrst_addr",  mem_addr,            32'h0);
    chk("mrst_valid", {31'b0, inst_valid}, 32'd0);
    chk("mrst_inst",  inst,                32'h0);
    chk("mrst_pc4",   inst_pc4,            32'h0);

    // Address wrap at the top of the 32-bit space
    reset   = 1'b1;
    mem_ack = 1'b1;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_valid",    {31'b0, inst_valid}, 32'd1);
    chk("wrap_pc4",      inst_pc4,            32'h0);
    chk("wrap_inst",     inst,                word_at(32'hFFFF_FFFC));
    chk("wrap_next_adr", mem_addr,            32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction prefetch stage sitting between the instruction memory and the IF/ID register of the pipelined CPU. Runs ahead of the pipeline: issues sequential word fetches over a req/ack handshake to a variable-latency instruction memory and buffers returned words with their PC+4 in a small FIFO. Presents one instruction per cycle to IF/ID, honours the hazard unit's hold, and flushes on a taken-branch redirect.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low: sampled 0 at a rising clk edge resets the block
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  32  word-aligned fetch address; stable while mem_req=1 and mem_ack=0
- mem_ack  in  1  memory accepts the request and returns data this cycle
- mem_rdata  in  32  instruction word, valid when mem_ack=1
- redirect  in  1  taken branch (branch AND zero); flush and refetch
- redirect_pc  in  32  branch target (beq adder result), word-aligned
- hold  in  1  hazard PC/IF-ID hold: do not pop
- inst_valid  out  1  head entry valid
- inst  out  32  head instruction; 32'h0 (nop) when empty
- inst_pc4  out  32  head instruction address + 4; 0 when empty

## Operation
- Registers: fetch_pc, FIFO (DEPTH × {inst, pc4}), rd/wr pointers (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH), fetch FSM.
- FSM states: IDLE (no request outstanding), WAIT (request outstanding, data kept), DROP (request outstanding, data to be discarded).
- IDLE -> WAIT when count < DEPTH: mem_req=1, mem_addr=fetch_pc.
- WAIT, mem_ack=1: push {mem_rdata, mem_addr+4}, fetch_pc += 4; stay WAIT with new address if post-push space remains, else IDLE.
- WAIT, mem_ack=0: hold mem_req/mem_addr unchanged (request never withdrawn).
- Pop: inst_valid=1 and hold=0 at the clock edge -> rd pointer advances.
- Push and pop same cycle: count unchanged; push into full FIFO impossible by issue rule.
- redirect=1 (priority over hold, push, pop): count, pointers cleared; fetch_pc <= redirect_pc. If WAIT with mem_ack=0 -> DROP (keep mem_req/old address until ack). If mem_ack=1 same cycle -> data discarded, next state IDLE. IDLE -> IDLE.
- DROP, mem_ack=1: discard data, -> IDLE. Second redirect in DROP: only fetch_pc updated.
- inst/inst_pc4/inst_valid are combinational from the head entry and count.
- Address arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc4=0, count=0, FSM=IDLE, fetch_pc=RESET_PC.
- Reset mid-request abandons the transaction; memory must tolerate req dropping on reset.
- First mem_req in the first cycle after reset deasserts.
- Ack at cycle N -> entry visible on inst at N+1 (no bypass).
- Zero-wait memory (mem_ack tied 1): one word per cycle sustained, back-to-back mem_req.
- Redirect at N -> earliest new-target request at N+1 (IDLE) or one cycle after the pending ack (DROP); new-target inst visible one cycle after its ack.
- At most one outstanding request.

## Structure
- Shared package/header fetch_defs: FSM encodings FS_IDLE/FS_WAIT/FS_DROP, NOP_INST=32'h0, INST_W=32.
- Sub-module fifo_sync (parameters WIDTH=64, DEPTH; push, pop, flush, full, empty, head data); FSM and fetch_pc in the top.

## Test plan
- Reset, mem_ack=1 constant: mem_addr 0,4,8,… on consecutive cycles; inst_valid first high 2 cycles after reset release; inst_pc4 = 4,8,12.
- hold=1 for 10 cycles, ack always 1: exactly 4 requests then mem_req=0, count=4; release hold -> pops resume, mem_req reasserts next cycle.
- Ack latency 3 cycles: mem_addr stable across wait; one entry per 4 cycles.
- redirect to 32'h40 while WAIT (ack pending): inst_valid=0 next cycle, old-address ack data never appears, next request addr 32'h40, first inst_pc4=32'h44.
- redirect with simultaneous ack and pop at count=2: FIFO empty next cycle, fetch data dropped, mem_addr=redirect_pc.
- reset=0 asserted mid-WAIT: all outputs at reset values next cycle, mem_addr=RESET_PC.
